clb_array: RTL and testbench
============================

# clb_array

Parametrised configurable logic block, successor to the single-lane 4-LUT CLB tile in the simpleFPGA fabric. It holds `LANES` independent slices that share one tile position. Each slice has a 16-entry LUT, an enable-gated flip-flop and four per-side output muxes. Configuration is loaded serially through a daisy-chainable shift register into a shadow copy. A commit step transfers it atomically to the active copy, so a fabric of tiles can be programmed with one bit-stream without glitching logic mid-load.

## Interface
Parameters:
- `LANES`, default 1: number of independent slices; each side bus is `LANES` bits wide.
- `LANE_CFG_W`, default 24: configuration bits per lane (fixed layout, see Operation).
- `CFG_W`, default `LANES*LANE_CFG_W`: total shadow/active register width (derived; not overridden).

Ports:
- `clk`, input, 1: single clock. All state is updated on its rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `up_i`, `down_i`, `right_i`, `left_i`, input, LANES each: per-side fabric inputs.
- `up_o`, `down_o`, `right_o`, `left_o`, output, LANES each: per-side fabric outputs.
- `cfg_shift_en`, input, 1: shift one configuration bit this cycle.
- `cfg_sdi`, input, 1: serial configuration data in.
- `cfg_sdo`, output, 1: serial data out, equal to `shadow[CFG_W-1]`, for chaining to the next tile.
- `cfg_commit`, input, 1: single-cycle request to copy shadow to active.
- `configured`, output, 1: active configuration is valid.
- `cfg_err`, output, 1: sticky error flag.

## Operation
- Lane `j` config slice `[24j+23 : 24j]`:
  - bit 23 `ff_init`.
  - bits 22:19 `out_sel` (up, down, right, left).
  - bit 18 `lut_sel` (1 = LUT, 0 = FF).
  - bits 17:16 `en_sel`: 00 = `left_i`, 01 = `right_i`, 10 = constant 1, 11 = `up_i`.
  - bits 15:0 `lut`.
- Lane address `a = {up_i[j], down_i[j], right_i[j], left_i[j]}`. `lut_out = lut[15 - a]`, so address 15 reads `lut[0]`.
- `sig = lut_sel ? lut_out : ff_q`.
- Output muxes:
  - `up_o[j] = out_sel[3] ? sig : down_i[j]`
  - `down_o[j] = out_sel[2] ? sig : up_i[j]`
  - `right_o[j] = out_sel[1] ? sig : left_i[j]`
  - `left_o[j] = out_sel[0] ? sig : right_i[j]`
- FF: `ff_q <= lut_out` when the selected enable is 1.
- While `configured == 0`:
  - `out_sel` is forced to 0 (pure pass-through).
  - The FF holds its value.
- Shift (`cfg_shift_en` high, `cfg_commit` low):
  - `shadow <= {shadow[CFG_W-2:0], cfg_sdi}`.
  - `bit_cnt` increments and saturates at `CFG_W`.
  - Shifting never touches the active copy.
- Commit when `bit_cnt == CFG_W`:
  - `active <= shadow`, `configured <= 1`, `bit_cnt <= 0`.
  - Every lane FF loads its `ff_init` (or 0, see Configuration).
- Commit when `bit_cnt != CFG_W`: ignored; `active`, `configured` and `bit_cnt` are unchanged; `cfg_err <= 1`.
- Shift and commit in the same cycle: commit is evaluated using the pre-shift state, the shift is dropped, and `cfg_err <= 1`.
- Shifting more than `CFG_W` bits is legal. The last `CFG_W` bits win, and the earlier bits exit via `cfg_sdo`.
- `cfg_err` clears only on reset.

## Timing
- Reset (`rst_n` low at a clock edge) clears: shadow, active, `bit_cnt`, `configured`, `cfg_err` and all FFs to 0.
- After reset:
  - Side outputs are pass-through: `up_o = down_i`, `down_o = up_i`, `right_o = left_i`, `left_o = right_i`.
  - `cfg_sdo = 0`.
- Reset mid-load or mid-operation discards everything; no partial state survives.
- Side-output paths are combinational from side inputs, active config and `ff_q`; there is no added latency.
- `cfg_sdo` changes one cycle after each shift.
- The new configuration is visible on the outputs in the cycle after the commit edge.

## Configuration
- `CLB_FF_INIT_EN` defined: on commit, each lane FF loads its config bit 23 (`ff_init`).
- `CLB_FF_INIT_EN` undefined: on commit, FFs load 0 and bit 23 is stored but ignored.
- Reset value of the FFs is 0 in both builds.

## Structure
- Package `clb_pkg` holds:
  - `LANE_CFG_W` and the field bit positions.
  - The `en_sel` encoding enum.
  - A packed struct `lane_cfg_t`.
- Sub-module `clb_lane` implements one lane (LUT, enable mux, FF, output muxes) and is instantiated `LANES` times.
- The top-level holds the shadow register, `bit_cnt`, commit logic and error flag.

## Test plan
- Reset with `LANES=1`, drive `up_i=1`, others 0 -> `down_o=1`, all other outputs 0, `configured=0`, `cfg_sdo=0`.
- Shift 24 bits encoding `lut=16'h8000` (AND of address 0 only) with `out_sel=4'b1111`, `lut_sel=1`, then commit -> `configured=1`; all inputs 0 gives all outputs 1; any input 1 gives outputs 0.
- Commit after 10 shifts -> `cfg_err=1`, `configured` unchanged, outputs still pass-through.
- FF lane with `en_sel=2'b00`, `lut=16'hFFFF`:
  - `left_i=0` -> `ff_q` holds.
  - `left_i=1` -> `ff_q=1` next cycle.
  - With `CLB_FF_INIT_EN` and `ff_init=1`, `ff_q=1` immediately after commit.
- `LANES=2` chain: shift 48 bits and check `cfg_sdo` reproduces the bit shifted in 48 cycles earlier. Shift 20 further bits during active operation -> outputs unchanged until the next valid commit.
- Shift and commit in the same cycle at `bit_cnt=CFG_W` -> commit applies pre-shift shadow and `cfg_err=1`. Then assert `rst_n=0` for one cycle -> all flags and outputs return to reset values.

Source files
------------

// File: rtl/clb_pkg.sv
// ----------------------------------------------------------------------------
// clb_pkg
// Shared definitions for the clb_array configurable logic block.
//   - LANE_CFG_W and the bit positions of every field in a lane config word
//   - en_sel_e : flip-flop enable source encoding
//   - lane_cfg_t : packed view of one lane's configuration word
//   - to_lane_cfg() : unpacks a raw lane word into lane_cfg_t
// ----------------------------------------------------------------------------
package clb_pkg;

    localparam int LANE_CFG_W  = 24;

    localparam int FF_INIT_BIT = 23;
    localparam int OUT_SEL_HI  = 22;
    localparam int OUT_SEL_LO  = 19;
    localparam int LUT_SEL_BIT = 18;
    localparam int EN_SEL_HI   = 17;
    localparam int EN_SEL_LO   = 16;
    localparam int LUT_HI      = 15;
    localparam int LUT_LO      = 0;

    typedef enum logic [1:0] {
        EN_LEFT  = 2'b00,
        EN_RIGHT = 2'b01,
        EN_ONE   = 2'b10,
        EN_UP    = 2'b11
    } en_sel_e;

    // out_sel bit order is {up, down, right, left}.
    typedef struct packed {
        logic        ff_init;
        logic [3:0]  out_sel;
        logic        lut_sel;
        en_sel_e     en_sel;
        logic [15:0] lut;
    } lane_cfg_t;

    function automatic lane_cfg_t to_lane_cfg(input logic [LANE_CFG_W-1:0] raw);
        lane_cfg_t c;
        c.ff_init = raw[FF_INIT_BIT];
        c.out_sel = raw[OUT_SEL_HI:OUT_SEL_LO];
        c.lut_sel = raw[LUT_SEL_BIT];
        c.en_sel  = en_sel_e'(raw[EN_SEL_HI:EN_SEL_LO]);
        c.lut     = raw[LUT_HI:LUT_LO];
        return c;
    endfunction

endpackage

// File: rtl/clb_lane.sv
// ----------------------------------------------------------------------------
// clb_lane
// One slice of the CLB: 16-entry LUT, enable-gated flip-flop, four side muxes.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   i_cfg              : active lane configuration
//   i_configured       : active configuration valid (else pass-through, FF holds)
//   i_commit_load      : commit this cycle; FF loads i_init_val
//   i_init_val         : value the FF takes on commit
//   i_up/down/right/left : side inputs (also the LUT address)
//   o_up/down/right/left : side outputs
// ----------------------------------------------------------------------------
module clb_lane
    import clb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  lane_cfg_t i_cfg,
    input  logic      i_configured,
    input  logic      i_commit_load,
    input  logic      i_init_val,
    input  logic      i_up,
    input  logic      i_down,
    input  logic      i_right,
    input  logic      i_left,
    output logic      o_up,
    output logic      o_down,
    output logic      o_right,
    output logic      o_left
);

    logic [3:0] w_addr;
    logic [3:0] w_out_sel;
    logic       w_lut_out;
    logic       w_en;
    logic       w_sig;
    logic       r_ff_q;
    logic       w_unused;

    // The commit-time FF value arrives separately on i_init_val, so the
    // stored ff_init field is intentionally not consumed here.
    assign w_unused = i_cfg.ff_init;

    // Address 15 reads lut[0]: the LUT word is stored MSB-first.
    assign w_addr    = {i_up, i_down, i_right, i_left};
    assign w_lut_out = i_cfg.lut[4'd15 - w_addr];

    // NOTE: default assignment before the case keeps this purely combinational.
    always_comb begin
        w_en = 1'b0;
        case (i_cfg.en_sel)
            EN_LEFT:  w_en = i_left;
            EN_RIGHT: w_en = i_right;
            EN_ONE:   w_en = 1'b1;
            EN_UP:    w_en = i_up;
            default:  w_en = 1'b0;
        endcase
    end

    // NOTE: state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ff_q <= 1'b0;
        end else if (i_commit_load) begin
            r_ff_q <= i_init_val;
        end else if (i_configured && w_en) begin
            r_ff_q <= w_lut_out;
        end
    end

    assign w_sig     = i_cfg.lut_sel ? w_lut_out : r_ff_q;
    assign w_out_sel = i_configured ? i_cfg.out_sel : 4'b0000;

    assign o_up    = w_out_sel[3] ? w_sig : i_down;
    assign o_down  = w_out_sel[2] ? w_sig : i_up;
    assign o_right = w_out_sel[1] ? w_sig : i_left;
    assign o_left  = w_out_sel[0] ? w_sig : i_right;

endmodule

// File: rtl/clb_array.sv
// ----------------------------------------------------------------------------
// clb_array
// LANES-wide configurable logic block with serial, daisy-chainable config.
// Bits shift into a shadow register; a commit copies shadow to the active
// copy atomically once exactly CFG_W bits (or more) have been shifted.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   up_i/down_i/right_i/left_i : per-side fabric inputs, LANES bits
//   up_o/down_o/right_o/left_o : per-side fabric outputs, LANES bits
//   cfg_shift_en, cfg_sdi      : serial configuration shift
//   cfg_sdo                    : shadow MSB, to the next tile's cfg_sdi
//   cfg_commit                 : request shadow -> active
//   configured                 : active configuration valid
//   cfg_err                    : sticky bad-commit flag, cleared by reset
// Build option CLB_FF_INIT_EN: lane FFs load ff_init (bit 23) on commit;
// otherwise they load 0.
// ----------------------------------------------------------------------------
module clb_array
    import clb_pkg::lane_cfg_t;
    import clb_pkg::to_lane_cfg;
#(
    parameter int LANES      = 1,
    parameter int LANE_CFG_W = clb_pkg::LANE_CFG_W,
    parameter int CFG_W      = LANES * LANE_CFG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LANES-1:0] up_i,
    input  logic [LANES-1:0] down_i,
    input  logic [LANES-1:0] right_i,
    input  logic [LANES-1:0] left_i,
    output logic [LANES-1:0] up_o,
    output logic [LANES-1:0] down_o,
    output logic [LANES-1:0] right_o,
    output logic [LANES-1:0] left_o,
    input  logic             cfg_shift_en,
    input  logic             cfg_sdi,
    output logic             cfg_sdo,
    input  logic             cfg_commit,
    output logic             configured,
    output logic             cfg_err
);

    localparam int               CNT_W    = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

    logic [CFG_W-1:0] r_shadow;
    logic [CFG_W-1:0] r_active;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_configured;
    logic             r_cfg_err;
    logic             w_full;
    logic             w_commit_ok;

    assign w_full      = (r_bit_cnt == CNT_FULL);
    assign w_commit_ok = cfg_commit && w_full;

    // Commit wins over shift: it sees the pre-shift state and the shift is
    // dropped. Any commit that is not clean (short count or a simultaneous
    // shift) raises the sticky error.
    // NOTE: shadow and active are plain flops, so reset wipes them entirely.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow     <= '0;
            r_active     <= '0;
            r_bit_cnt    <= '0;
            r_configured <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else if (cfg_commit) begin
            if (w_full) begin
                r_active     <= r_shadow;
                r_configured <= 1'b1;
                r_bit_cnt    <= '0;
            end
            if (!w_full || cfg_shift_en) begin
                r_cfg_err <= 1'b1;
            end
        end else if (cfg_shift_en) begin
            r_shadow <= {r_shadow[CFG_W-2:0], cfg_sdi};
            if (!w_full) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    assign cfg_sdo    = r_shadow[CFG_W-1];
    assign configured = r_configured;
    assign cfg_err    = r_cfg_err;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        lane_cfg_t w_cfg;
        logic      w_init_val;

        assign w_cfg = to_lane_cfg(r_active[j*LANE_CFG_W +: LANE_CFG_W]);

        // The FF init bit comes from the shadow being committed, not from
        // the outgoing active copy.
`ifdef CLB_FF_INIT_EN
        assign w_init_val = r_shadow[j*LANE_CFG_W + clb_pkg::FF_INIT_BIT];
`else
        assign w_init_val = 1'b0;
`endif

        clb_lane u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_cfg         (w_cfg),
            .i_configured  (r_configured),
            .i_commit_load (w_commit_ok),
            .i_init_val    (w_init_val),
            .i_up          (up_i[j]),
            .i_down        (down_i[j]),
            .i_right       (right_i[j]),
            .i_left        (left_i[j]),
            .o_up          (up_o[j]),
            .o_down        (down_o[j]),
            .o_right       (right_o[j]),
            .o_left        (left_o[j])
        );
    end

endmodule

// File: tb/tb_clb_array.sv
// ----------------------------------------------------------------------------
// tb_clb_array
// Directed bench for clb_array: a LANES=1 instance (dut A) and a LANES=2
// instance (dut B) sharing clock and reset. Expected values are hand-derived
// from the config words shifted in. Honours CLB_FF_INIT_EN for the FF value
// expected right after a commit.
// ----------------------------------------------------------------------------
module tb_clb_array;

`ifdef CLB_FF_INIT_EN
    localparam logic FF_INIT_EXP = 1'b1;
`else
    localparam logic FF_INIT_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    // dut A, LANES = 1
    logic [0:0] a_up, a_down, a_right, a_left;
    logic [0:0] a_up_o, a_down_o, a_right_o, a_left_o;
    logic       a_shift, a_sdi, a_sdo, a_commit, a_conf, a_err;

    // dut B, LANES = 2
    logic [1:0] b_up, b_down, b_right, b_left;
    logic [1:0] b_up_o, b_down_o, b_right_o, b_left_o;
    logic       b_shift, b_sdi, b_sdo, b_commit, b_conf, b_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clb_array #(.LANES(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .up_i(a_up), .down_i(a_down), .right_i(a_right), .left_i(a_left),
        .up_o(a_up_o), .down_o(a_down_o), .right_o(a_right_o), .left_o(a_left_o),
        .cfg_shift_en(a_shift), .cfg_sdi(a_sdi), .cfg_sdo(a_sdo),
        .cfg_commit(a_commit), .configured(a_conf), .cfg_err(a_err)
    );

    clb_array #(.LANES(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .up_i(b_up), .down_i(b_down), .right_i(b_right), .left_i(b_left),
        .up_o(b_up_o), .down_o(b_down_o), .right_o(b_right_o), .left_o(b_left_o),
        .cfg_shift_en(b_shift), .cfg_sdi(b_sdi), .cfg_sdo(b_sdo),
        .cfg_commit(b_commit), .configured(b_conf), .cfg_err(b_err)
    );

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then step clear of it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_a(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            a_shift = 1'b1;
            a_sdi   = v[i];
            tick();
        end
        a_shift = 1'b0;
        a_sdi   = 1'b0;
    endtask

    task automatic commit_a();
        a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
    endtask

    task automatic shift_b_ones(input int n);
        for (int i = 0; i < n; i++) begin
            b_shift = 1'b1;
            b_sdi   = 1'b1;
            tick();
        end
        b_shift = 1'b0;
        b_sdi   = 1'b0;
    endtask

    task automatic commit_b();
        b_commit = 1'b1;
        tick();
        b_commit = 1'b0;
    endtask

    function automatic logic [3:0] a_outs();
        return {a_up_o, a_down_o, a_right_o, a_left_o};
    endfunction

    function automatic logic [7:0] b_outs();
        return {b_up_o, b_down_o, b_right_o, b_left_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [47:0] cfg48;
        logic [7:0]  junk;
        logic [55:0] seq;

        rst_n = 1'b0;
        {a_up, a_down, a_right, a_left, a_shift, a_sdi, a_commit} = '0;
        {b_up, b_down, b_right, b_left, b_shift, b_sdi, b_commit} = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state: pass-through, flags low.
        a_up = 1'b1;
        #1;
        check("rst_outs",   48'(a_outs()), 48'h4);
        check("rst_conf",   48'(a_conf),   48'h0);
        check("rst_sdo",    48'(a_sdo),    48'h0);
        check("rst_err",    48'(a_err),    48'h0);

        // Short commit after 10 shifts: error, still unconfigured.
        shift_a(24'h0003FF, 10);
        commit_a();
        check("short_err",  48'(a_err),    48'h1);
        check("short_conf", 48'(a_conf),   48'h0);
        check("short_outs", 48'(a_outs()), 48'h4);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rst2_err",   48'(a_err),    48'h0);

        // Over-length load (5 extra leading bits), then AND-of-zero LUT.
        a_up = 1'b0;
        shift_a(24'h00001F, 5);
        shift_a(24'h7C8000, 24);
        commit_a();
        check("and_conf",   48'(a_conf),   48'h1);
        check("and_err",    48'(a_err),    48'h0);
        check("and_zero",   48'(a_outs()), 48'hF);
        a_up = 1'b1;
        #1;
        check("and_up",     48'(a_outs()), 48'h0);
        a_up = 1'b0;
        a_left = 1'b1;
        #1;
        check("and_left",   48'(a_outs()), 48'h0);
        a_left = 1'b0;

        // FF lane: en=left, lut=FFFF, lut_sel=0, ff_init=1.
        shift_a(24'hF8FFFF, 24);
        commit_a();
        check("ff_init",    48'(a_outs()), 48'({4{FF_INIT_EXP}}));
        tick();
        check("ff_hold0",   48'(a_outs()), 48'({4{FF_INIT_EXP}}));
        a_left = 1'b1;
        tick();
        check("ff_set",     48'(a_outs()), 48'hF);
        a_left = 1'b0;
        tick();
        check("ff_hold1",   48'(a_outs()), 48'hF);

        // FF lane: en=const 1, lut=0000, ff_init=1.
        shift_a(24'hFA0000, 24);
        commit_a();
        check("ff2_init",   48'(a_outs()), 48'({4{FF_INIT_EXP}}));
        tick();
        check("ff2_clr",    48'(a_outs()), 48'h0);

        // Shift and commit together: pre-shift shadow commits, shift dropped.
        shift_a(24'h7C8000, 24);
        a_shift  = 1'b1;
        a_sdi    = 1'b1;
        a_commit = 1'b1;
        tick();
        {a_shift, a_sdi, a_commit} = '0;
        check("both_err",   48'(a_err),    48'h1);
        check("both_conf",  48'(a_conf),   48'h1);
        check("both_sdo",   48'(a_sdo),    48'h0);
        check("both_zero",  48'(a_outs()), 48'hF);
        a_up = 1'b1;
        #1;
        check("both_up",    48'(a_outs()), 48'h0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rst3_conf",  48'(a_conf),   48'h0);
        check("rst3_err",   48'(a_err),    48'h0);
        check("rst3_sdo",   48'(a_sdo),    48'h0);
        check("rst3_outs",  48'(a_outs()), 48'h4);

        // LANES=2 chain: 8 junk bits then lane1=AND-of-0, lane0=AND-of-15.
        cfg48 = {24'h7C8000, 24'h7C0001};
        junk  = 8'b1011_0010;
        for (int k = 0; k < 8; k++) seq[k] = junk[7-k];
        for (int k = 0; k < 48; k++) seq[8+k] = cfg48[47-k];
        for (int n = 1; n <= 56; n++) begin
            b_shift = 1'b1;
            b_sdi   = seq[n-1];
            tick();
            if (n >= 48) check("chain_sdo", 48'(b_sdo), 48'(seq[n-48]));
            else         check("chain_sdo", 48'(b_sdo), 48'h0);
        end
        b_shift = 1'b0;
        b_sdi   = 1'b0;
        commit_b();
        check("b_conf",     48'(b_conf),   48'h1);
        check("b_err",      48'(b_err),    48'h0);
        check("b_zero",     48'(b_outs()), 48'hAA);
        {b_up, b_down, b_right, b_left} = 8'h55;
        #1;
        check("b_mixed",    48'(b_outs()), 48'hFF);
        {b_up, b_down, b_right, b_left} = 8'h00;

        // Extra shifts while active leave outputs alone; short commit errs.
        shift_b_ones(20);
        check("b_live",     48'(b_outs()), 48'hAA);
        commit_b();
        check("b_short_err",  48'(b_err),    48'h1);
        check("b_short_outs", 48'(b_outs()), 48'hAA);
        shift_b_ones(28);
        commit_b();
        check("b_ones",     48'(b_outs()), 48'hFF);
        check("b_conf2",    48'(b_conf),   48'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
